// File: rtl/mdio_phy_responder_if.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder_if
// Clause-22 MDIO management bus as seen at the PHY pins.
//   mdc       : management clock from the MAC-side master
//   mdio_in   : MDIO line level as observed by the responder
//   mdio_out  : level the responder drives when mdio_oen = 0
//   mdio_oen  : 1 = responder releases the line, 0 = responder drives mdio_out
// Modports:
//   master : MAC side (drives mdc/mdio_in, observes responder drive)
//   slave  : PHY responder side
// -----------------------------------------------------------------------------
interface mdio_phy_responder_if;
  logic mdc;
  logic mdio_in;
  logic mdio_out;
  logic mdio_oen;

  modport master (
    output mdc,
    output mdio_in,
    input  mdio_out,
    input  mdio_oen
  );

  modport slave (
    input  mdc,
    input  mdio_in,
    output mdio_out,
    output mdio_oen
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder
// PHY-side IEEE 802.3 Clause-22 MDIO responder. MDC and MDIO are oversampled on
// clk (clk must be at least 8x MDC); frames addressed to PHY_ADDR are decoded and
// served from a small 16-bit register file. Accepted writes are reported to user
// logic through wr_strobe/wr_regad/wr_data.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   mdio_bus   slave modport of mdio_phy_responder_if (mdc, mdio_in, mdio_out, mdio_oen)
//   link_up    in   live link status, visible in reg1[2]
//   wr_strobe  out  one-cycle pulse on every accepted write to PHY_ADDR
//   wr_regad   out  register address of the last accepted write
//   wr_data    out  data of the last accepted write
//   frame_err  out  one-cycle pulse on a malformed frame (bad ST or OP)
//
// Register map:
//   0    control, RW, bit15 = self-clearing soft reset of all RW registers
//   1    status, RO, {9'b0111_1001_0, 4'b0, link_up, 2'b01}
//   2/3  PHY identifier, RO (PHY_ID1 / PHY_ID2)
//   4-7  user scratch, RW, reset 0
//   8-31 read as zero, writes discarded
//
// Build option:
//   MDIO_PREAMBLE_SUPPRESSION_EN  when defined, a single preamble 1 before ST is
//   enough (suppressed-preamble mode); otherwise 32 consecutive 1s are required.
// -----------------------------------------------------------------------------
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'h10,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2,
  parameter logic [15:0] CTRL_DEFAULT = 16'h1140
) (
  input  logic                       clk,
  input  logic                       reset,
  mdio_phy_responder_if.slave        mdio_bus,
  input  logic                       link_up,
  output logic                       wr_strobe,
  output logic [4:0]                 wr_regad,
  output logic [15:0]                wr_data,
  output logic                       frame_err
);

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
  localparam logic [5:0] PRE_MIN = 6'd1;
`else
  localparam logic [5:0] PRE_MIN = 6'd32;
`endif

  typedef enum logic [2:0] {
    S_PRE   = 3'd0,
    S_ST1   = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6,
    S_SKIP  = 3'd7
  } state_t;

  // Synchronisers and edge detector
  logic [1:0]  mdc_sync_q;
  logic        mdc_prev_q;
  logic [1:0]  mdio_sync_q;
  logic        mdc_rise;
  logic        mdio_bit;

  // Frame decode state
  state_t      state_q;
  logic [5:0]  ones_q;
  logic [4:0]  bit_cnt_q;
  logic        op_first_q;
  logic        is_read_q;
  logic [4:0]  phyad_q;
  logic [4:0]  regad_q;
  logic [14:0] data_q;
  logic [15:0] rd_shift_q;

  // Registered outputs
  logic        mdio_out_q;
  logic        mdio_oen_q;
  logic        wr_strobe_q;
  logic        frame_err_q;
  logic [4:0]  wr_regad_q;
  logic [15:0] wr_data_q;

  // Register file
  logic [15:0] ctrl_q;
  logic [15:0] user_q [4];

  // Next values formed from the bit currently on the line
  logic [4:0]  regad_d;
  logic [15:0] data_d;
  logic [15:0] rd_mux;

  assign mdc_rise = mdc_sync_q[1] & ~mdc_prev_q;
  assign mdio_bit = mdio_sync_q[1];
  assign regad_d  = {regad_q[3:0], mdio_bit};
  assign data_d   = {data_q, mdio_bit};

  // Two-flop synchronisers for MDC/MDIO; idle-high reset avoids a false MDC edge
  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_sync_q  <= 2'b11;
      mdc_prev_q  <= 1'b1;
      mdio_sync_q <= 2'b11;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], mdio_bus.mdc};
      mdc_prev_q  <= mdc_sync_q[1];
      mdio_sync_q <= {mdio_sync_q[0], mdio_bus.mdio_in};
    end
  end

  // Read mux addressed by the full REGAD, used to snapshot read data at end of REGAD
  always_comb begin
    rd_mux = 16'h0000;
    case (regad_d)
      5'd0:    rd_mux = ctrl_q;
      5'd1:    rd_mux = {9'b0111_1001_0, 4'b0000, link_up, 2'b01};
      5'd2:    rd_mux = PHY_ID1;
      5'd3:    rd_mux = PHY_ID2;
      5'd4, 5'd5, 5'd6, 5'd7:
               rd_mux = user_q[regad_d[1:0]];
      default: rd_mux = 16'h0000;
    endcase
  end

  // Frame FSM, line drive, write commit and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_PRE;
      ones_q      <= 6'd0;
      bit_cnt_q   <= 5'd0;
      op_first_q  <= 1'b0;
      is_read_q   <= 1'b0;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      data_q      <= 15'd0;
      rd_shift_q  <= 16'h0000;
      mdio_out_q  <= 1'b1;
      mdio_oen_q  <= 1'b1;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_regad_q  <= 5'd0;
      wr_data_q   <= 16'h0000;
      ctrl_q      <= CTRL_DEFAULT;
      for (int i = 0; i < 4; i++) begin
        user_q[i] <= 16'h0000;
      end
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (mdc_rise) begin
        case (state_q)
          S_PRE: begin
            if (mdio_bit) begin
              if (ones_q != 6'd63) begin
                ones_q <= ones_q + 6'd1;
              end else begin
                ones_q <= ones_q;
              end
            end else begin
              // This 0 is the first ST bit when enough preamble preceded it
              if (ones_q >= PRE_MIN) begin
                state_q <= S_ST1;
              end else begin
                state_q <= S_PRE;
              end
              ones_q <= 6'd0;
            end
          end

          S_ST1: begin
            if (mdio_bit) begin
              state_q   <= S_OP;
              bit_cnt_q <= 5'd0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_PRE;
            end
          end

          S_OP: begin
            if (bit_cnt_q == 5'd0) begin
              op_first_q <= mdio_bit;
              bit_cnt_q  <= 5'd1;
            end else if (op_first_q != mdio_bit) begin
              // 10 = read, 01 = write: the first OP bit alone tells them apart
              is_read_q <= op_first_q;
              state_q   <= S_PHYAD;
              bit_cnt_q <= 5'd0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_PRE;
              bit_cnt_q   <= 5'd0;
            end
          end

          S_PHYAD: begin
            phyad_q <= {phyad_q[3:0], mdio_bit};
            if (bit_cnt_q == 5'd4) begin
              state_q   <= S_REGAD;
              bit_cnt_q <= 5'd0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end

          S_REGAD: begin
            regad_q <= regad_d;
            if (bit_cnt_q == 5'd4) begin
              bit_cnt_q  <= 5'd0;
              rd_shift_q <= rd_mux;
              if (phyad_q == PHY_ADDR) begin
                state_q <= S_TA;
              end else begin
                state_q <= S_SKIP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end

          S_TA: begin
            // Outputs set here are for the following bit period: after TA bit 1
            // the responder drives 0 for TA bit 2, after TA bit 2 it drives D15.
            if (bit_cnt_q == 5'd0) begin
              bit_cnt_q <= 5'd1;
              if (is_read_q) begin
                mdio_oen_q <= 1'b0;
                mdio_out_q <= 1'b0;
              end else begin
                mdio_oen_q <= 1'b1;
                mdio_out_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= 5'd0;
              state_q   <= S_DATA;
              if (is_read_q) begin
                mdio_out_q <= rd_shift_q[15];
                rd_shift_q <= {rd_shift_q[14:0], 1'b0};
              end else begin
                mdio_out_q <= 1'b1;
              end
            end
          end

          S_DATA: begin
            data_q <= data_d[14:0];
            if (bit_cnt_q == 5'd15) begin
              state_q    <= S_PRE;
              bit_cnt_q  <= 5'd0;
              mdio_oen_q <= 1'b1;
              mdio_out_q <= 1'b1;
              if (!is_read_q) begin
                wr_strobe_q <= 1'b1;
                wr_regad_q  <= regad_q;
                wr_data_q   <= data_d;
                case (regad_q)
                  5'd0: begin
                    // Soft reset: bit15 never lands in ctrl, so it reads back 0
                    if (data_d[15]) begin
                      ctrl_q <= CTRL_DEFAULT;
                      for (int i = 0; i < 4; i++) begin
                        user_q[i] <= 16'h0000;
                      end
                    end else begin
                      ctrl_q <= data_d;
                    end
                  end
                  5'd4, 5'd5, 5'd6, 5'd7: begin
                    user_q[regad_q[1:0]] <= data_d;
                  end
                  default: begin
                    ctrl_q <= ctrl_q;
                  end
                endcase
              end else begin
                wr_strobe_q <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (is_read_q) begin
                mdio_out_q <= rd_shift_q[15];
                rd_shift_q <= {rd_shift_q[14:0], 1'b0};
              end else begin
                mdio_out_q <= 1'b1;
              end
            end
          end

          S_SKIP: begin
            // Frame for another PHY: let TA + DATA (18 bits) pass untouched
            if (bit_cnt_q == 5'd17) begin
              state_q   <= S_PRE;
              bit_cnt_q <= 5'd0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end

          default: begin
            state_q    <= S_PRE;
            bit_cnt_q  <= 5'd0;
            ones_q     <= 6'd0;
            mdio_oen_q <= 1'b1;
            mdio_out_q <= 1'b1;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign mdio_bus.mdio_out = mdio_out_q;
  assign mdio_bus.mdio_oen = mdio_oen_q;
  assign wr_strobe         = wr_strobe_q;
  assign wr_regad          = wr_regad_q;
  assign wr_data           = wr_data_q;
  assign frame_err         = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// tb_mdio_phy_responder
// Directed bench for mdio_phy_responder: a table of whole MDIO frames with
// hand-computed expectations, plus a hand-written mid-frame reset sequence.
// clk period 10 ns, MDC period 80 ns (8 clk), bench acts on clk negedges.
// -----------------------------------------------------------------------------
module tb_mdio_phy_responder;

  logic        clk;
  logic        reset;
  logic        link_up;
  logic        wr_strobe;
  logic [4:0]  wr_regad;
  logic [15:0] wr_data;
  logic        frame_err;

  mdio_phy_responder_if bus ();

  mdio_phy_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mdio_bus  (bus),
    .link_up   (link_up),
    .wr_strobe (wr_strobe),
    .wr_regad  (wr_regad),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  // system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  // pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_strobe) wr_cnt = wr_cnt + 1;
      if (frame_err) err_cnt = err_cnt + 1;
      if (wr_strobe && frame_err) both_cnt = both_cnt + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // one MDC bit: change mdio_in with MDC low, observe the line just before MDC rises
  task automatic bit_io(input logic b, output logic oen, output logic dout);
    bus.mdc     = 1'b0;
    bus.mdio_in = b;
    #40;
    oen  = bus.mdio_oen;
    dout = bus.mdio_out;
    bus.mdc = 1'b1;
    #40;
  endtask

  task automatic send_hdr(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
    logic o, d;
    for (int i = 0; i < pre; i++) bit_io(1'b1, o, d);
    bit_io(1'b0, o, d);
    bit_io(1'b1, o, d);
    bit_io(op[1], o, d);
    bit_io(op[0], o, d);
    for (int i = 4; i >= 0; i--) bit_io(pa[i], o, d);
    for (int i = 4; i >= 0; i--) bit_io(ra[i], o, d);
  endtask

  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input int stall,
                           output logic [15:0] rd, output int drv, output logic ta2_ok, output logic oen_end);
    logic o, d;
    logic is_wr;
    is_wr  = (op == 2'b01);
    drv    = 0;
    rd     = 16'h0000;
    send_hdr(pre, op, pa, ra);
    bit_io(1'b1, o, d);
    if (!o) drv++;
    bit_io(is_wr ? 1'b0 : 1'b1, o, d);
    if (!o) drv++;
    ta2_ok = (!o && !d);
    for (int i = 15; i >= 0; i--) begin
      if (i == stall) #2000;
      bit_io(is_wr ? wd[i] : 1'b1, o, d);
      if (!o) drv++;
      rd[i] = d;
    end
    bit_io(1'b1, o, d);
    oen_end = o;
  endtask

  typedef struct {
    string       name;
    int          pre;
    logic [1:0]  op;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic        link;
    int          stall;
    logic [15:0] exp_rd;
    int          exp_drv;
    int          exp_wr;
    int          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input int pre, input logic [1:0] op, input logic [4:0] pa,
                              input logic [4:0] ra, input logic [15:0] wd, input logic link, input int stall,
                              input logic [15:0] exp_rd, input int exp_drv, input int exp_wr, input int exp_err);
    vec_t v;
    v.name = name; v.pre = pre; v.op = op; v.pa = pa; v.ra = ra; v.wd = wd; v.link = link; v.stall = stall;
    v.exp_rd = exp_rd; v.exp_drv = exp_drv; v.exp_wr = exp_wr; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b01;

  initial begin
    logic [15:0] rd;
    int          drv;
    logic        ta2_ok, oen_end, o, d;
    int          w0, e0;
    int          short_drv;

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
    short_drv = 17;
`else
    short_drv = 0;
`endif

    //   name            pre op  pa     ra     wd        lnk stall exp_rd    drv wr err
    add("rd_id1",        32, RD, 5'h10, 5'd2,  16'h0000, 0, -1, 16'h0141, 17, 0, 0);
    add("wr_r4",         32, WR, 5'h10, 5'd4,  16'hA5C3, 0, -1, 16'h0000,  0, 1, 0);
    add("rd_r4",         32, RD, 5'h10, 5'd4,  16'h0000, 0, -1, 16'hA5C3, 17, 0, 0);
    add("rd_r1_l0",      32, RD, 5'h10, 5'd1,  16'h0000, 0, -1, 16'h7901, 17, 0, 0);
    add("rd_r1_l1",      32, RD, 5'h10, 5'd1,  16'h0000, 1, -1, 16'h7905, 17, 0, 0);
    add("wr_r1_ro",      32, WR, 5'h10, 5'd1,  16'hFFFF, 1, -1, 16'h0000,  0, 1, 0);
    add("rd_r1_keep",    32, RD, 5'h10, 5'd1,  16'h0000, 1, -1, 16'h7905, 17, 0, 0);
    add("rd_id2",        32, RD, 5'h10, 5'd3,  16'h0000, 0, -1, 16'h0CC2, 17, 0, 0);
    add("rd_r0",         32, RD, 5'h10, 5'd0,  16'h0000, 0, -1, 16'h1140, 17, 0, 0);
    add("rd_other_pa",   32, RD, 5'h01, 5'd2,  16'h0000, 0, -1, 16'h0000,  0, 0, 0);
    add("wr_other_pa",   32, WR, 5'h01, 5'd4,  16'h0000, 0, -1, 16'h0000,  0, 0, 0);
    add("rd_r4_kept",    32, RD, 5'h10, 5'd4,  16'h0000, 0, -1, 16'hA5C3, 17, 0, 0);
    add("op11",          32, 2'b11, 5'h10, 5'd2, 16'h0000, 0, -1, 16'h0000, 0, 0, 1);
    add("rd_after_err",  32, RD, 5'h10, 5'd2,  16'h0000, 0, -1, 16'h0141, 17, 0, 0);
    add("op00",          32, 2'b00, 5'h10, 5'd2, 16'h0000, 0, -1, 16'h0000, 0, 0, 1);
    add("short_pre",     10, RD, 5'h10, 5'd2,  16'h0000, 0, -1, 16'h0141, short_drv, 0, 0);
    add("wr_r8",         32, WR, 5'h10, 5'd8,  16'hBEEF, 0, -1, 16'h0000,  0, 1, 0);
    add("rd_r8",         32, RD, 5'h10, 5'd8,  16'h0000, 0, -1, 16'h0000, 17, 0, 0);
    add("wr_r7",         32, WR, 5'h10, 5'd7,  16'h1234, 0, -1, 16'h0000,  0, 1, 0);
    add("rd_r7_stall",   32, RD, 5'h10, 5'd7,  16'h0000, 0,  7, 16'h1234, 17, 0, 0);
    add("wr_r5",         32, WR, 5'h10, 5'd5,  16'h5555, 0, -1, 16'h0000,  0, 1, 0);
    add("wr_r0_srst",    32, WR, 5'h10, 5'd0,  16'h8000, 0, -1, 16'h0000,  0, 1, 0);
    add("rd_r4_dflt",    32, RD, 5'h10, 5'd4,  16'h0000, 0, -1, 16'h0000, 17, 0, 0);
    add("rd_r7_dflt",    32, RD, 5'h10, 5'd7,  16'h0000, 0, -1, 16'h0000, 17, 0, 0);
    add("rd_r5_dflt",    32, RD, 5'h10, 5'd5,  16'h0000, 0, -1, 16'h0000, 17, 0, 0);
    add("rd_r0_dflt",    32, RD, 5'h10, 5'd0,  16'h0000, 0, -1, 16'h1140, 17, 0, 0);
    add("wr_r0",         32, WR, 5'h10, 5'd0,  16'h0100, 0, -1, 16'h0000,  0, 1, 0);
    add("rd_r0_new",     32, RD, 5'h10, 5'd0,  16'h0000, 0, -1, 16'h0100, 17, 0, 0);
    add("wr_r6",         32, WR, 5'h10, 5'd6,  16'h6666, 0, -1, 16'h0000,  0, 1, 0);
    add("rd_r6",         32, RD, 5'h10, 5'd6,  16'h0000, 0, -1, 16'h6666, 17, 0, 0);

    // reset state
    reset       = 1'b1;
    link_up     = 1'b0;
    bus.mdc     = 1'b0;
    bus.mdio_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_oen",       bus.mdio_oen, 1);
    check("rst_out",       bus.mdio_out, 1);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_wr_regad",  wr_regad, 0);
    check("rst_wr_data",   wr_data, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v       = vecs[k];
      link_up = v.link;
      w0      = wr_cnt;
      e0      = err_cnt;
      run_frame(v.pre, v.op, v.pa, v.ra, v.wd, v.stall, rd, drv, ta2_ok, oen_end);
      check({v.name, "_drive_bits"}, drv, v.exp_drv);
      if (v.exp_drv == 17) begin
        check({v.name, "_ta2_zero"}, ta2_ok, 1);
        check({v.name, "_rdata"}, rd, v.exp_rd);
      end
      check({v.name, "_oen_end"}, oen_end, 1);
      check({v.name, "_wr_pulses"}, wr_cnt - w0, v.exp_wr);
      check({v.name, "_err_pulses"}, err_cnt - e0, v.exp_err);
      if (v.exp_wr == 1) begin
        check({v.name, "_wr_regad"}, wr_regad, v.ra);
        check({v.name, "_wr_data"}, wr_data, v.wd);
      end
    end

    // reset in the middle of a read DATA phase (reg0 currently 0x0100)
    w0 = wr_cnt;
    send_hdr(32, RD, 5'h10, 5'd0);
    bit_io(1'b1, o, d);
    bit_io(1'b1, o, d);
    for (int i = 0; i < 4; i++) bit_io(1'b1, o, d);
    check("mid_read_driving", bus.mdio_oen, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_read_rst_oen", bus.mdio_oen, 1);
    check("mid_read_rst_out", bus.mdio_out, 1);
    repeat (3) @(negedge clk);
    bus.mdc = 1'b0;
    reset   = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_read_rst_no_wr", wr_cnt - w0, 0);

    // reset restored the register file
    run_frame(32, RD, 5'h10, 5'd0, 16'h0000, -1, rd, drv, ta2_ok, oen_end);
    check("post_rst_r0_drive", drv, 17);
    check("post_rst_r0", rd, 16'h1140);
    run_frame(32, RD, 5'h10, 5'd6, 16'h0000, -1, rd, drv, ta2_ok, oen_end);
    check("post_rst_r6", rd, 16'h0000);
    check("post_rst_oen_end", oen_end, 1);

    check("strobe_and_err_together", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
